ram8_chip: RTL and testbench



---
 rtl/ram8_chip_pkg.sv | 6 +
 rtl/mux_chip_2to1.sv | 13 +
 rtl/ram8_chip_register.sv | 32 +++
 rtl/ram8_chip.sv | 61 ++++++
 tb/tb_ram8_chip.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram8_chip_pkg.sv
// Shared sizing constants for the RAM chip family (RAM8, RAM64 and up).
package ram8_chip_pkg;
    localparam int WORD_WIDTH  = 16;
    localparam int RAM8_DEPTH  = 8;
    localparam int RAM8_ADDR_W = 3;
endpackage

// File: rtl/mux_chip_2to1.sv
// Word-wide 2:1 multiplexer: out = s ? b : a.
module mux_chip_2to1
    import ram8_chip_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] out
);
    assign out = s ? b : a;
endmodule

// File: rtl/ram8_chip_register.sv
// register_chip: WIDTH bit cells, each a 2:1 mux (hold vs. new input) feeding a DFF.
module register_chip
    import ram8_chip_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    genvar b;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_cell
            logic next;

            mux_chip_2to1 #(.WIDTH(1)) u_mux (
                .a   (out[b]),
                .b   (in[b]),
                .s   (load),
                .out (next)
            );

            // Reset overrides the mux so a simultaneous load is discarded.
            always_ff @(posedge clk) begin
                if (rst) out[b] <= 1'b0;
                else     out[b] <= next;
            end
        end
    endgenerate
endmodule

// File: rtl/ram8_chip.sv
// 8 x 16 RAM: synchronous write through a load demux, combinational read through a 2:1 mux tree.
module ram8_chip
    import ram8_chip_pkg::*;
#(
    parameter int WIDTH  = WORD_WIDTH,
    parameter int DEPTH  = RAM8_DEPTH,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WIDTH-1:0]  out
);
    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] word_load;
    logic [WIDTH-1:0] lvl1  [4];
    logic [WIDTH-1:0] lvl2  [2];

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_word
            assign word_load[i] = load && (address == ADDR_W'(i));

            register_chip #(.WIDTH(WIDTH)) u_reg (
                .clk  (clk),
                .rst  (rst),
                .load (word_load[i]),
                .in   (in),
                .out  (words[i])
            );
        end

        // Tree is sized for the fixed 8-word depth: address[0] picks at the leaves.
        for (i = 0; i < 4; i++) begin : g_lvl1
            mux_chip_2to1 #(.WIDTH(WIDTH)) u_mux (
                .a   (words[2*i]),
                .b   (words[2*i+1]),
                .s   (address[0]),
                .out (lvl1[i])
            );
        end

        for (i = 0; i < 2; i++) begin : g_lvl2
            mux_chip_2to1 #(.WIDTH(WIDTH)) u_mux (
                .a   (lvl1[2*i]),
                .b   (lvl1[2*i+1]),
                .s   (address[1]),
                .out (lvl2[i])
            );
        end
    endgenerate

    mux_chip_2to1 #(.WIDTH(WIDTH)) u_root (
        .a   (lvl2[0]),
        .b   (lvl2[1]),
        .s   (address[2]),
        .out (out)
    );
endmodule

// File: tb/tb_ram8_chip.sv
// Self-checking bench for ram8_chip against a reference word array and an expected queue.
module tb_ram8_chip;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load;
    logic [15:0] out;

    logic [15:0] model [8];
    logic [15:0] exp_q [$];
    logic [15:0] exp;
    int          checks = 0;
    int          errors = 0;

    ram8_chip dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .address (address),
        .load    (load),
        .out     (out)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge, so they are stable for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] a);
        exp_q.push_back(model[a]);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; in = 16'h0; address = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            push_exp(3'(i));
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d got=%h exp=%h", i, out, exp);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            push_exp(3'(i));
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL fill_readback addr=%0d got=%h exp=%h", i, out, exp);
            end
        end
    endtask

    task automatic test_read_during_write();
        do_write(3'd5, 16'h00FF);
        address = 3'd5; in = 16'hABCD; load = 1'b1;
        #1;
        checks++;
        if (out !== 16'h00FF) begin
            errors++;
            $display("FAIL rdw_before_edge got=%h exp=%h", out, 16'h00FF);
        end
        tick();
        load = 1'b0;
        model[5] = 16'hABCD;
        push_exp(3'd5);
        exp = exp_q.pop_front();
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL rdw_after_edge got=%h exp=%h", out, exp);
        end
    endtask

    task automatic test_load_gating();
        do_write(3'd2, 16'h1234);
        address = 3'd2; in = 16'hFFFF; load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            push_exp(3'd2);
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL load_gating edge=%0d got=%h exp=%h", k, out, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        do_write(3'd7, 16'hBEEF);
        rst = 1'b1; load = 1'b1; in = 16'h5555; address = 3'd7;
        tick();
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        for (int i = 7; i >= 0; i--) begin
            address = 3'(i);
            push_exp(3'(i));
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL reset_priority addr=%0d got=%h exp=%h", i, out, exp);
            end
        end
    endtask

    task automatic test_extremes();
        for (int i = 1; i < 7; i++) do_write(3'(i), 16'($urandom_range(0, 65535)));
        do_write(3'd0, 16'hFFFF);
        do_write(3'd7, 16'h8001);
        // Toggle within one clock period so no edge intervenes.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            address = (k % 2 == 0) ? 3'd0 : 3'd7;
            push_exp(address);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL extremes_toggle addr=%0d got=%h exp=%h", address, out, exp);
            end
        end
        for (int i = 1; i < 7; i++) begin
            address = 3'(i);
            push_exp(3'(i));
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL extremes_hold addr=%0d got=%h exp=%h", i, out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  a;
        logic [15:0] d;
        logic        ld;
        tick();
        do_write(3'd3, 16'h1357);
        do_write(3'd3, 16'h2468);
        address = 3'd3;
        push_exp(3'd3);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL b2b_same_addr got=%h exp=%h", out, exp);
        end
        for (int n = 0; n < 40; n++) begin
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom_range(0, 65535));
            ld = 1'($urandom_range(0, 1));
            address = a; in = d; load = ld;
            push_exp(a);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL b2b_pre_edge n=%0d addr=%0d got=%h exp=%h", n, a, out, exp);
            end
            tick();
            if (ld) model[a] = d;
            push_exp(a);
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL b2b_post_edge n=%0d addr=%0d got=%h exp=%h", n, a, out, exp);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            push_exp(3'(i));
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL b2b_final addr=%0d got=%h exp=%h", i, out, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_during_write();
        test_load_gating();
        test_reset_priority();
        test_extremes();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
